// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver and the planned transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned OS_RATE = 16;
  localparam int unsigned SAMP_W  = $clog2(OS_RATE);
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BIT_W   = $clog2(DATA_W);

  localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(7);
  localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(8);
  localparam logic [SAMP_W-1:0] SAMP_C    = SAMP_W'(9);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OS_RATE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  function automatic int unsigned uart_os_div(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / (baud * OS_RATE);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divide-by-DIV counter with a
// synchronous clear so the tick phase can be aligned to a start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned       CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, 16x oversampling, majority vote of samples 7/8/9.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra Parity_Err strobe.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Int,
  output logic       Frame_Err,
`ifdef UART_RX_PARITY_EN
  output logic       Parity_Err,
`endif
  output logic       Busy
);

  localparam int unsigned OS_DIV = uart_os_div(CLK_FREQ, BAUD);

  if (OS_DIV < 2) begin : g_div_chk
    $error("uart_byte_rx: OS_DIV must be at least 2");
  end

  logic              sync1_q, sync2_q, prev_q;
  logic              fall_s, tick_s, tick_clr_s, eval_s, wrap_s, maj_s, good_s;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [BIT_W-1:0]  bit_idx_q;
  logic [7:0]        shift_q, rx_byte_q;
  logic              vote_a_q, vote_b_q;
  logic              rx_int_q, frame_err_q, busy_q;
  uart_state_e       state_q;
`ifdef UART_RX_PARITY_EN
  logic              par_ok_q, par_err_q;
`endif

  // Two-flop synchronizer plus previous value for falling-edge detection.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= Rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick_clr_s = (state_q == ST_IDLE);

  uart_baud_tick #(.DIV(OS_DIV)) u_tick (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .clear_i (tick_clr_s),
    .tick_o  (tick_s)
  );

  // Decision strobes: vote is resolved as the sample counter reaches 9.
  always_comb begin
    fall_s = prev_q & ~sync2_q;
    samp_d = samp_q + SAMP_W'(1);
    eval_s = tick_s && (samp_d == SAMP_C);
    wrap_s = tick_s && (samp_q == SAMP_LAST);
    maj_s  = maj3(vote_a_q, vote_b_q, sync2_q);
`ifdef UART_RX_PARITY_EN
    good_s = maj_s & par_ok_q;
`else
    good_s = maj_s;
`endif
  end

  // Receive FSM with sample counter, vote capture and registered strobes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      samp_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      vote_a_q    <= 1'b0;
      vote_b_q    <= 1'b0;
      rx_int_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q    <= 1'b1;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_int_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (tick_s) begin
        samp_q <= samp_d;
        if (samp_d == SAMP_A) vote_a_q <= sync2_q;
        if (samp_d == SAMP_B) vote_b_q <= sync2_q;
      end
      case (state_q)
        ST_IDLE: begin
          samp_q <= '0;
          if (fall_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (eval_s && maj_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (wrap_s) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (eval_s) shift_q[bit_idx_q] <= maj_s;
          if (wrap_s) begin
            if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + BIT_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (eval_s) par_ok_q <= (maj_s == ^shift_q);
          if (wrap_s) state_q <= ST_STOP;
        end
`endif
        ST_STOP: begin
          // Leave at mid-stop so the next start edge is never missed.
          if (eval_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (good_s) begin
              rx_byte_q <= shift_q;
              rx_int_q  <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            par_err_q <= ~par_ok_q;
            par_ok_q  <= 1'b1;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Rx_Byte   = rx_byte_q;
  assign Rx_Int    = rx_int_q;
  assign Frame_Err = frame_err_q;
  assign Busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign Parity_Err = par_err_q;
`endif

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
Asynchronous serial receiver, 8N1, LSB first, 16x oversampling with majority-vote bit sampling.
Sits directly upstream of the command-frame parser. Delivers each received byte on Rx_Byte with a one-cycle Rx_Int strobe.
The parser consumes the byte stream and extracts the frame AA 03 A B C 88.
Also flags framing errors, for debug LEDs and counters.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line baud rate
OS_DIV, CLK_FREQ/(BAUD*16), clocks per oversample tick; integer truncation; elaboration error if < 2

Ports:
Clk  in  1  system clock
Rst  in  1  reset, synchronous, active-high; one clock domain, all logic on rising Clk
Rx  in  1  raw asynchronous serial line, idle high
Rx_Byte  out  8  last correctly received byte; holds until next good byte
Rx_Int  out  1  one-cycle strobe: Rx_Byte just updated
Frame_Err  out  1  one-cycle strobe: stop bit sampled low, byte discarded
Busy  out  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset values: Rx_Byte=0x00, Rx_Int=0, Frame_Err=0, Busy=0, synchronizer FFs=1, state=IDLE, all counters=0.
- Rx passes through a 2-FF synchronizer. Falling-edge detection uses the synced value and its previous value.
- Tick generator: counter 0..OS_DIV-1. Pulses tick when counter=OS_DIV-1. Counter is cleared in IDLE and on start-edge detection, so phase aligns to the start edge.
- Sample counter 0..15 advances per tick. The bit value is the majority of samples 7, 8 and 9, evaluated when the counter reaches 9.
- The bit ends when the counter wraps at 15.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on synced falling edge go to START and set Busy=1.
- START: if majority=1 (glitch or false start), go to IDLE with no outputs. Otherwise, at wrap, go to DATA with bit_idx=0.
- DATA: shift the majority value into shift_reg[bit_idx], LSB first. At wrap after bit_idx=7 go to STOP; otherwise bit_idx++.
- STOP, evaluated at sample 9:
  - majority=1: Rx_Byte<=shift_reg, Rx_Int=1 next cycle.
  - majority=0: Frame_Err=1 next cycle; Rx_Byte unchanged.
  - Either way, go to IDLE immediately at sample 9, without waiting for the full stop bit. This tolerates up to about 3% baud mismatch on back-to-back frames.
- Busy deasserts on the cycle IDLE is entered.
- Rx_Int and Frame_Err are never high together and are never high for more than one cycle.
- A new falling edge in the same cycle IDLE is entered is honoured (back-to-back frames).
- Rx held low (break) gives Frame_Err once, then waits in IDLE for a high-then-low transition.
- Reset asserted mid-frame: the frame is abandoned and all outputs return to reset values on the next edge; no strobe is produced.
- Latency: Rx_Int is 2 synchronizer cycles plus (9.5 bit times approx.) after the start edge.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame becomes 8E1. A PARITY state is inserted between DATA and STOP; its majority bit must equal XOR(shift_reg).
- On mismatch the byte is discarded and Frame_Err pulses at the stop-bit decision.
- An extra port Parity_Err (out, 1) pulses together with Frame_Err in that case.
- Undefined: 8N1, no PARITY state, no Parity_Err port.

Decomposition:
- Package uart_pkg: state enum (IDLE/START/DATA/PARITY/STOP), OS_RATE=16, sample indices SAMP_A=7, SAMP_B=8, SAMP_C=9, a function computing OS_DIV, and the widths from $clog2.
- Sub-module uart_baud_tick: oversample tick counter with sync clear; reused by the planned transmitter.

Test Plan:
All tests use CLK_FREQ=50e6 and BAUD=115200, giving OS_DIV=27 and 432 clocks per bit.
- Send 0xAA at nominal rate -> exactly one Rx_Int pulse, Rx_Byte=0xAA, Frame_Err never high, Busy low afterwards.
- Back-to-back 0xAA,0x03,0x01,0x12,0x34,0x88 with zero idle gap -> six Rx_Int pulses in order, matching bytes; parser downstream issues a write to addr 0x01 with data 0x1234.
- Low glitch on Rx of 100 clocks in idle -> no Rx_Int, no Frame_Err, Busy returns to 0 by mid-start.
- Send 0x55 with stop bit forced 0 -> Frame_Err one pulse, no Rx_Int, Rx_Byte keeps previous value.
- Send 0x3C at BAUD +2.5% and -2.5% -> Rx_Byte=0x3C each time; assert Rst during bit 4 of a frame -> no strobe, Rx_Byte=0x00.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> Rx_Byte=0x07. 0x07 with parity bit 0 -> Frame_Err and Parity_Err pulse, no Rx_Int.
